// File: rtl/muldiv_sequencer_if.sv
// Control-unit handshake and ALU datapath bundle
// for the multi-cycle MULTU/DIVU sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic [WIDTH-1:0] alu_lop;
  logic [WIDTH-1:0] alu_rop;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport master (
    output start, mode, a, b,
    output alu_result, alu_zero,
    input  busy, done, hi, lo, div_by_zero,
    input  alu_lop, alu_rop, alu_op
  );

  modport slave (
    input  start, mode, a, b,
    input  alu_result, alu_zero,
    output busy, done, hi, lo, div_by_zero,
    output alu_lop, alu_rop, alu_op
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequencer running shift-add multiply and restoring
// divide through the shared single-cycle ALU.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  muldiv_sequencer_if.slave bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SLT = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_CMP,
    DIV_SUB,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] rem_sh;
  logic             last;
  logic             carry;

  // Shifted partial remainder; fits in WIDTH bits
  // because the remainder before bit k is < 2^k.
  assign rem_sh = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));
  assign carry  = (bus.alu_result < hi_q);

  assign bus.busy = (state_q == MUL) ||
                    (state_q == DIV_CMP) ||
                    (state_q == DIV_SUB);
  assign bus.done        = (state_q == DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

  // ALU operand/op selection per state
  always_comb begin
    bus.alu_lop = '0;
    bus.alu_rop = '0;
    bus.alu_op  = OP_ADD;
    unique case (state_q)
      MUL: begin
        bus.alu_lop = hi_q;
        bus.alu_rop = lo_q[0] ? opnd_q : '0;
      end
      DIV_CMP: begin
        bus.alu_op  = OP_SLT;
        bus.alu_lop = rem_sh;
        bus.alu_rop = opnd_q;
      end
      DIV_SUB: begin
        bus.alu_op  = OP_SUB;
        bus.alu_lop = hi_q;
        bus.alu_rop = opnd_q;
      end
      default: ;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dbz_d = 1'b0;
          cnt_d = '0;
          if (!bus.mode) begin
            hi_d    = '0;
            lo_d    = bus.b;
            opnd_d  = bus.a;
            state_d = MUL;
          end else if (bus.b != '0) begin
            hi_d    = '0;
            lo_d    = bus.a;
            opnd_d  = bus.b;
            state_d = DIV_CMP;
          end else begin
            hi_d    = bus.a;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      MUL: begin
        {hi_d, lo_d} = {carry, bus.alu_result,
                        lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last) state_d = DONE;
      end
      DIV_CMP: begin
        hi_d = rem_sh;
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
        if (bus.alu_zero) begin
          state_d = DIV_SUB;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = last ? DONE : DIV_CMP;
        end
      end
      DIV_SUB: begin
        hi_d    = bus.alu_result;
        lo_d[0] = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last ? DONE : DIV_CMP;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer
// with a behavioural ALU and arithmetic reference model.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    case (bus.alu_op)
      2'b00:   bus.alu_result = bus.alu_lop + bus.alu_rop;
      2'b01:   bus.alu_result = bus.alu_lop - bus.alu_rop;
      2'b10:   bus.alu_result = {31'd0, bus.alu_lop < bus.alu_rop};
      default: bus.alu_result = 32'hDEAD_BEEF;
    endcase
  end
  assign bus.alu_zero = (bus.alu_result == 32'd0);

  // Continuous ALU-interface sanity checks
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.alu_op === 2'b11) begin
        failures++;
        $display("FAIL alu_op_illegal got=%b want!=11", bus.alu_op);
      end
      if (!bus.busy) begin
        checks++;
        if (bus.alu_lop !== 32'd0 || bus.alu_rop !== 32'd0 ||
            bus.alu_op !== 2'b00) begin
          failures++;
          $display("FAIL alu_idle got=%h/%h/%b want=0/0/00",
                   bus.alu_lop, bus.alu_rop, bus.alu_op);
        end
      end
    end
  end

  // Issues one operation and measures it; no checking here.
  task automatic run_op(input bit m, input logic [31:0] av,
                        input logic [31:0] bv, input int restart_at,
                        output int nbusy, output bit got_done,
                        output logic [31:0] hi_o,
                        output logic [31:0] lo_o,
                        output logic dbz_o, output bit done_twice);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    nbusy = 0;
    got_done = 1'b0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        if (bus.busy) nbusy++;
        if (restart_at > 0 && nbusy == restart_at) begin
          bus.start = 1'b1;
          bus.a = ~av;
          bus.b = bv + 32'd5;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    hi_o  = bus.hi;
    lo_o  = bus.lo;
    dbz_o = bus.div_by_zero;
    @(negedge clk);
    done_twice = bus.done;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 ||
        bus.lo !== 32'd0 || bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%b%b %h %h %b want=00 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo, bus.div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_multiply();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] p;
    logic [31:0] hi, lo;
    logic dbz;
    int nb;
    bit gd, d2;
    ta[0] = 32'd7;        tb[0] = 32'd6;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF;
    ta[2] = 32'd0;        tb[2] = 32'h12345678;
    ta[3] = 32'h80000000; tb[3] = 32'd2;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] x, y;
      if (i < 4) begin
        x = ta[i];
        y = tb[i];
      end else begin
        x = $urandom;
        y = $urandom;
      end
      p = {32'd0, x} * {32'd0, y};
      run_op(1'b0, x, y, 0, nb, gd, hi, lo, dbz, d2);
      checks++;
      if (!gd || hi !== p[63:32] || lo !== p[31:0] || dbz !== 1'b0) begin
        failures++;
        $display("FAIL mul %h*%h got=%b %h_%h dbz=%b want=1 %h dbz=0",
                 x, y, gd, hi, lo, dbz, p);
      end
      checks++;
      if (nb != 32 || d2 !== 1'b0) begin
        failures++;
        $display("FAIL mul_timing %h*%h got busy=%0d done2=%b want 32 0",
                 x, y, nb, d2);
      end
    end
  endtask

  task automatic test_divide();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [31:0] hi, lo, q, r;
    logic dbz;
    int nb;
    bit gd, d2;
    ta[0] = 32'd100;      tb[0] = 32'd7;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'd1;
    ta[2] = 32'd5;        tb[2] = 32'd9;
    ta[3] = 32'hFFFFFFFF; tb[3] = 32'hFFFFFFFF;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] x, y;
      if (i < 4) begin
        x = ta[i];
        y = tb[i];
      end else begin
        x = $urandom;
        y = $urandom >> $urandom_range(0, 31);
        if (y == 32'd0) y = 32'd3;
      end
      q = x / y;
      r = x % y;
      run_op(1'b1, x, y, 0, nb, gd, hi, lo, dbz, d2);
      checks++;
      if (!gd || lo !== q || hi !== r || dbz !== 1'b0) begin
        failures++;
        $display("FAIL div %h/%h got=%b q=%h r=%h dbz=%b want q=%h r=%h",
                 x, y, gd, lo, hi, dbz, q, r);
      end
      checks++;
      if (nb != 32 + $countones(q) || d2 !== 1'b0) begin
        failures++;
        $display("FAIL div_timing %h/%h got busy=%0d done2=%b want %0d 0",
                 x, y, nb, d2, 32 + $countones(q));
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] hi, lo;
    logic dbz;
    int nb;
    bit gd, d2;
    run_op(1'b1, 32'd1234, 32'd0, 0, nb, gd, hi, lo, dbz, d2);
    checks++;
    if (!gd || nb != 0 || hi !== 32'd1234 || lo !== 32'hFFFFFFFF ||
        dbz !== 1'b1) begin
      failures++;
      $display("FAIL div0 got done=%b busy=%0d %h %h dbz=%b want 1 0 4d2 ffffffff 1",
               gd, nb, hi, lo, dbz);
    end
    checks++;
    if (bus.div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL div0_hold got=%b want=1", bus.div_by_zero);
    end
    run_op(1'b0, 32'd2, 32'd3, 0, nb, gd, hi, lo, dbz, d2);
    checks++;
    if (!gd || lo !== 32'd6 || hi !== 32'd0 || dbz !== 1'b0) begin
      failures++;
      $display("FAIL div0_clear got=%b %h %h dbz=%b want 1 0 6 0",
               gd, hi, lo, dbz);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] hi, lo;
    logic dbz;
    int nb;
    bit gd, d2;
    run_op(1'b0, 32'd1000, 32'd3000, 10, nb, gd, hi, lo, dbz, d2);
    checks++;
    if (!gd || nb != 32 || hi !== 32'd0 || lo !== 32'd3000000) begin
      failures++;
      $display("FAIL restart_ignored got=%b busy=%0d %h %h want 1 32 0 %h",
               gd, nb, hi, lo, 32'd3000000);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_idle got busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] hi, lo;
    logic dbz;
    int nb;
    bit gd, d2, seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b1;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_busy got=%b want=1", bus.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 ||
        bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL async_reset got=%b%b %h %h want=00 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_no_done got=1 want=0");
    end
    run_op(1'b1, 32'd100, 32'd7, 0, nb, gd, hi, lo, dbz, d2);
    checks++;
    if (!gd || nb != 35 || lo !== 32'd14 || hi !== 32'd2) begin
      failures++;
      $display("FAIL post_reset_div got=%b busy=%0d q=%h r=%h want 1 35 e 2",
               gd, nb, lo, hi);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller that implements unsigned 32x32 multiply (MULTU) and unsigned 32/32 divide (DIVU) on top of the single-cycle datapath ALU.
- The ALU op encoding is Add=2'b00, Sub=2'b01, Slt=2'b10 (unsigned less-than, result 1/0); zero flag = (result==0).
- The sequencer drives the ALU operand and op inputs and consumes its result and zero flag.
- It holds the HI/LO result registers and handshakes with the main control unit through start/busy/done.

Parameters:
- WIDTH, 32, operand, ALU and HI/LO width; only 32 is verified.
- CNT_W, 6, iteration-counter width; must hold WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = multiply, 1 = divide
- a  in  32  multiplicand / dividend, sampled with start
- b  in  32  multiplier / divisor, sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- div_by_zero  out  1  last divide had b==0; held until next accepted start
- alu_lop  out  32  ALU left operand
- alu_rop  out  32  ALU right operand
- alu_op  out  2  ALU op
- alu_result  in  32  ALU result
- alu_zero  in  1  ALU zero flag

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, cnt=0, internal mcand/divisor regs=0.
- Reset mid-operation aborts with no done pulse.
- ALU outputs are combinational from state. In IDLE/DONE: alu_lop=0, alu_rop=0, alu_op=Add.
- States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE.
- busy=1 in MUL, DIV_CMP, DIV_SUB. done=1 only in DONE; DONE always lasts one cycle, then IDLE.
- IDLE with start=1 (accepted start):
  - Clears div_by_zero, cnt=0.
  - mode=0: hi=0, lo=b, mcand=a, go to MUL.
  - mode=1, b!=0: hi=0, lo=a, divisor=b, go to DIV_CMP.
  - mode=1, b==0: hi=a, lo=32'hFFFFFFFF, div_by_zero=1, go to DONE (done on the next cycle).
- start outside IDLE is ignored; a, b and mode are don't-care there.
- MUL (one cycle per bit, 32 cycles):
  - Drives alu_op=Add, alu_lop=hi, alu_rop = lo[0] ? mcand : 0.
  - carry = (alu_result < hi), internal unsigned compare.
  - Update: {hi,lo} <= {carry, alu_result, lo[31:1]}; cnt++.
  - After the step with cnt==31, go to DONE.
- DIV_CMP (restoring division, MSB first):
  - Drives R' = {hi[30:0], lo[31]}, alu_op=Slt, alu_lop=R', alu_rop=divisor.
  - Update: hi<=R', lo<={lo[30:0],0}.
  - alu_zero=1 (R' >= divisor): go to DIV_SUB.
  - Otherwise: cnt++, then DONE if cnt was 31, else DIV_CMP.
  - R' never exceeds 32 bits, because before bit k the partial remainder is < 2^k; no carry handling is needed.
- DIV_SUB:
  - Drives alu_op=Sub, alu_lop=hi, alu_rop=divisor.
  - Update: hi<=alu_result, lo[0]<=1, cnt++.
  - Then DONE if cnt was 31, else DIV_CMP.
- Latency, measured from the start-sampling edge:
  - Multiply: busy 32 cycles, done in cycle 33.
  - Divide: busy 32 + popcount(quotient) cycles (32..64).
  - Divide by zero: busy never asserted, done in cycle 1.
- hi/lo hold their value from DONE until the next accepted start. They hold intermediate values while busy, and consumers must not read them then.
- alu_op never takes value 2'b11.

Test Plan:
- Multiply 7 x 6 -> after 32 busy cycles done pulses once; hi=0, lo=42; div_by_zero=0.
- Multiply 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. This exercises the carry path every cycle.
- Divide 100 / 7 -> lo=14, hi=2; busy for 35 cycles (quotient has 3 ones).
  - Divide 32'hFFFFFFFF / 1 -> lo=32'hFFFFFFFF, hi=0, busy exactly 64 cycles.
  - Divide 5 / 9 -> lo=0, hi=5, busy 32 cycles.
- Divide 1234 / 0 -> done in the cycle after start, busy never high; hi=1234, lo=32'hFFFFFFFF, div_by_zero=1.
  - A following multiply 2 x 3 clears div_by_zero, then lo=6.
- Start pulsed again at cycle 10 of a multiply, with different a/b -> ignored; the original result is delivered on schedule.
- rst asserted at cycle 15 of a divide -> busy, done, hi, lo all 0 immediately, no done pulse; the next start runs normally.
- Throughout all tests, the ALU is modelled per its encoding, and the bench checks alu_op is never 2'b11 and that ALU outputs are 0/Add in IDLE.
